// File: rtl/monostable_pulse_pkg.sv
// Shared control types for the one-shot pulse generator.
// Holds the FSM state encoding and the idle trigger code.
package monostable_pulse_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [1:0] TRIG_IDLE = 2'b00;

endpackage

// File: rtl/monostable_pulse_if.sv
// Trigger/pulse bundle between a requester and the one-shot.
// The master drives the trigger code; the slave returns the pulse.
interface monostable_pulse_if;
  import monostable_pulse_pkg::*;

  logic [1:0] trigger;
  logic       pulse;

  modport master (
    output trigger,
    input  pulse
  );

  modport slave (
    input  trigger,
    output pulse
  );

endinterface

// File: rtl/monostable_pulse_sync_ff.sv
// N-stage bit-vector synchronizer with async active-low clear.
// Reusable for any asynchronous control input.
module sync_ff #(
  parameter int W = 1,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [N-1:0][W-1:0] st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0;
    end else begin
      st <= {st[N-2:0], d};
    end
  end

  assign q = st[N-1];

endmodule

// File: rtl/monostable_pulse.sv
// One-shot: fires a PULSE_CYCLES-wide strobe on each
// change of the synchronized trigger to a new non-zero code.
module monostable_pulse
  import monostable_pulse_pkg::*;
#(
  parameter int PULSE_CYCLES = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic           reloj,
  input  logic           resetM,
  monostable_pulse_if.slave bus
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(PULSE_CYCLES - 1);

  logic [1:0]    trig_s;
  logic [1:0]    trig_p;
  logic          evt;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          pulse_q;

  sync_ff #(
    .W (2),
    .N (SYNC_STAGES)
  ) u_sync (
    .clk   (reloj),
    .rst_n (resetM),
    .d     (bus.trigger),
    .q     (trig_s)
  );

  // trig_p tracks even while ACTIVE so dropped changes never fire later
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      trig_p <= TRIG_IDLE;
    end else begin
      trig_p <= trig_s;
    end
  end

  assign evt = (trig_s != trig_p) && (trig_s != TRIG_IDLE);

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      state   <= IDLE;
      cnt     <= '0;
      pulse_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (evt) begin
            state   <= ACTIVE;
            cnt     <= LOAD;
            pulse_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state   <= IDLE;
            pulse_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.pulse = pulse_q;

endmodule

// File: tb/tb_monostable_pulse.sv
// Scoreboard bench: two instances (1-cycle and 4-cycle pulses),
// expected pulses queued at stimulus time, checked on pulse fall.
module tb_monostable_pulse;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1;
  logic rst4;

  monostable_pulse_if b1 ();
  monostable_pulse_if b4 ();

  monostable_pulse #(
    .PULSE_CYCLES (1),
    .SYNC_STAGES  (2)
  ) dut1 (
    .reloj  (clk),
    .resetM (rst1),
    .bus    (b1.slave)
  );

  monostable_pulse #(
    .PULSE_CYCLES (4),
    .SYNC_STAGES  (2)
  ) dut4 (
    .reloj  (clk),
    .resetM (rst4),
    .bus    (b4.slave)
  );

  typedef struct {
    int start;
    int width;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc++;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor for dut1
  int   st1;
  int   w1;
  logic p1 = 1'b0;
  exp_t e1;
  always @(negedge clk) begin
    if (b1.pulse === 1'b1) begin
      if (!p1) begin
        st1 = cyc;
        w1  = 0;
      end
      w1++;
    end else if (p1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_pulse_start", st1, -1);
      end else begin
        e1 = q1.pop_front();
        check("dut1_start", st1, e1.start);
        check("dut1_width", w1, e1.width);
      end
    end
    p1 = (b1.pulse === 1'b1);
  end

  // monitor for dut4
  int   st4;
  int   w4;
  logic p4 = 1'b0;
  exp_t e4;
  always @(negedge clk) begin
    if (b4.pulse === 1'b1) begin
      if (!p4) begin
        st4 = cyc;
        w4  = 0;
      end
      w4++;
    end else if (p4) begin
      if (q4.size() == 0) begin
        check("dut4_unexpected_pulse_start", st4, -1);
      end else begin
        e4 = q4.pop_front();
        check("dut4_start", st4, e4.start);
        check("dut4_width", w4, e4.width);
      end
    end
    p4 = (b4.pulse === 1'b1);
  end

  // change trigger just after an edge; a firing change is
  // sampled on the next edge and pulses 3 edges after the drive edge
  task automatic drive(int which, logic [1:0] code, bit fire,
                       int w, int gap);
    exp_t e;
    @(posedge clk);
    #2;
    e.start = cyc + 3;
    e.width = w;
    if (which == 1) begin
      b1.trigger = code;
      if (fire) q1.push_back(e);
    end else begin
      b4.trigger = code;
      if (fire) q4.push_back(e);
    end
    repeat (gap) @(posedge clk);
  endtask

  int   n;
  exp_t ex;

  initial begin
    rst1 = 1'b0;
    rst4 = 1'b0;
    b1.trigger = 2'd0;
    b4.trigger = 2'd0;

    // held in reset: trigger activity must not reach pulse
    #50;
    b1.trigger = 2'd1;
    #100;
    check("rst_hold_pulse_a", int'(b1.pulse), 0);
    #50;
    b1.trigger = 2'd2;
    #100;
    check("rst_hold_pulse_b", int'(b1.pulse), 0);
    #100;
    b1.trigger = 2'd3;
    #50;
    check("rst_hold_pulse_c", int'(b1.pulse), 0);
    check("rst_hold_pulse4", int'(b4.pulse), 0);
    b1.trigger = 2'd0;
    repeat (3) @(posedge clk);
    #2;
    rst1 = 1'b1;
    rst4 = 1'b1;
    repeat (5) @(posedge clk);

    // single event, then a full code sequence
    drive(1, 2'd1, 1'b1, 1, 15);
    drive(1, 2'd2, 1'b1, 1, 15);
    drive(1, 2'd3, 1'b1, 1, 15);
    drive(1, 2'd1, 1'b1, 1, 15);
    drive(1, 2'd3, 1'b1, 1, 15);
    drive(1, 2'd2, 1'b1, 1, 15);
    drive(1, 2'd0, 1'b0, 1, 15);

    // 3 ns glitch between edges is never sampled
    @(posedge clk);
    #3;
    b1.trigger = 2'd2;
    #3;
    b1.trigger = 2'd0;
    repeat (10) @(posedge clk);
    drive(1, 2'd2, 1'b1, 1, 15);

    // 4-cycle instance: plain pulse
    drive(4, 2'd1, 1'b1, 4, 15);
    // change during ACTIVE is dropped and never fires later
    drive(4, 2'd2, 1'b1, 4, 2);
    drive(4, 2'd3, 1'b0, 4, 20);
    drive(4, 2'd0, 1'b0, 4, 10);

    // reset mid-pulse: only the first high cycle is seen
    @(posedge clk);
    #2;
    b4.trigger = 2'd3;
    n = cyc;
    ex.start = n + 3;
    ex.width = 1;
    q4.push_back(ex);
    repeat (4) @(posedge clk);
    #2;
    rst4 = 1'b0;
    #1;
    check("reset_drops_pulse", int'(b4.pulse), 0);
    repeat (3) @(posedge clk);
    #2;
    rst4 = 1'b1;
    ex.start = cyc + 3;
    ex.width = 4;
    q4.push_back(ex);
    repeat (20) @(posedge clk);

    @(negedge clk);
    check("q1_drained", q1.size(), 0);
    check("q4_drained", q4.size(), 0);
    check("pulse1_idle_end", int'(b1.pulse), 0);
    check("pulse4_idle_end", int'(b4.pulse), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
